rf_frame_serializer: RTL

Packet framer and serializer that sits directly upstream of the Manchester encoder. It accepts a frame length and payload bytes over a valid/ready byte interface. It emits a NRZ bit stream of preamble, sync word, length, payload and CRC-8, at one bit per clk2x cycle, on bit_out/bit_en. bit_out feeds the encoder's din and bit_en feeds its enable.

---
 rtl/rf_frame_serializer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rf_frame_serializer.sv
// rtl/rf_frame_serializer.sv - frame builder and NRZ bit serializer ahead of the Manchester encoder
module rf_frame_serializer #(
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = 16'h2DD4,
    parameter bit          USE_CRC        = 1'b1
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       bit_out,
    output logic       bit_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CRC
    } state_t;

    localparam logic [7:0] PRE_BYTE = 8'hAA;
    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic [7:0] fetched_q, fetched_d;
    logic       bit_out_q, bit_out_d;
    logic       bit_en_q, bit_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       byte_ready_q, byte_ready_d;

    logic [7:0] cur_byte;
    logic [7:0] crc_next;

    // One serial CRC-8 step (poly 0x07, MSB-first).
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Byte currently on the wire and CRC including the bit on bit_out now.
    always_comb begin
        cur_byte = 8'h00;
        crc_next = crc_q;
        case (state_q)
            S_PRE:   cur_byte = PRE_BYTE;
            S_SYNC:  cur_byte = byte_cnt_q[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
            S_LEN:   cur_byte = len_q;
            S_PAY:   cur_byte = shift_q;
            S_CRC:   cur_byte = crc_q;
            default: cur_byte = 8'h00;
        endcase
        if (state_q == S_LEN || state_q == S_PAY) begin
            crc_next = crc_step(crc_q, bit_out_q);
        end
    end

    // Next-state, bit sequencing, holding buffer and registered output values.
    always_comb begin
        logic       pay_start;
        logic       tail;
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        crc_d        = crc_q;
        shift_d      = shift_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        fetched_d    = fetched_q;
        bit_out_d    = 1'b0;
        bit_en_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pay_start    = 1'b0;
        tail         = 1'b0;

        if (byte_valid && byte_ready_q) begin
            buf_d      = byte_data;
            buf_full_d = 1'b1;
            fetched_d  = fetched_q + 8'd1;
        end

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d    = S_PRE;
                len_d      = len;
                crc_d      = 8'h00;
                bit_idx_d  = 3'd7;
                byte_cnt_d = 8'd0;
                buf_full_d = 1'b0;
                fetched_d  = 8'd0;
                busy_d     = 1'b1;
                bit_en_d   = 1'b1;
                bit_out_d  = PRE_BYTE[7];
            end
        end else begin
            crc_d = crc_next;
            if (bit_idx_q != 3'd0) begin
                bit_idx_d = bit_idx_q - 3'd1;
                bit_en_d  = 1'b1;
                bit_out_d = cur_byte[bit_idx_q - 3'd1];
            end else begin
                bit_idx_d = 3'd7;
                case (state_q)
                    S_PRE: begin
                        bit_en_d = 1'b1;
                        if (byte_cnt_q == PRE_LAST) begin
                            state_d    = S_SYNC;
                            byte_cnt_d = 8'd0;
                            bit_out_d  = SYNC_WORD[15];
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            bit_out_d  = PRE_BYTE[7];
                        end
                    end
                    S_SYNC: begin
                        bit_en_d = 1'b1;
                        if (byte_cnt_q[0] == 1'b0) begin
                            byte_cnt_d = 8'd1;
                            bit_out_d  = SYNC_WORD[7];
                        end else begin
                            state_d    = S_LEN;
                            byte_cnt_d = 8'd0;
                            bit_out_d  = len_q[7];
                        end
                    end
                    S_LEN: begin
                        byte_cnt_d = 8'd0;
                        if (len_q == 8'd0) tail = 1'b1;
                        else               pay_start = 1'b1;
                    end
                    S_PAY: begin
                        if (byte_cnt_q == len_q - 8'd1) begin
                            tail = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            pay_start  = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                endcase

                // A payload byte must come out of the holding buffer now or the frame aborts.
                if (pay_start) begin
                    if (buf_full_q) begin
                        state_d    = S_PAY;
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        bit_en_d   = 1'b1;
                        bit_out_d  = buf_q[7];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end

                // After LEN/payload: either the CRC byte or the end of the frame.
                if (tail) begin
                    if (USE_CRC) begin
                        state_d   = S_CRC;
                        bit_en_d  = 1'b1;
                        bit_out_d = crc_next[7];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        end

        byte_ready_d = busy_d & ~buf_full_d & (fetched_d < len_d);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_idx_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            len_q        <= 8'd0;
            crc_q        <= 8'd0;
            shift_q      <= 8'd0;
            buf_q        <= 8'd0;
            buf_full_q   <= 1'b0;
            fetched_q    <= 8'd0;
            bit_out_q    <= 1'b0;
            bit_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            fetched_q    <= fetched_d;
            bit_out_q    <= bit_out_d;
            bit_en_q     <= bit_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign bit_out    = bit_out_q;
    assign bit_en     = bit_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
